// File: rtl/distinct_window_detector_pkg.sv
// Shared constants for the distinct-window detector: colour codes, default
// symbol geometry and a ceiling-log2 helper used to size the len port.
package distinct_window_detector_pkg;

    localparam logic [1:0] COL_G = 2'd0;
    localparam logic [1:0] COL_B = 2'd1;
    localparam logic [1:0] COL_R = 2'd2;

    localparam int SYM_W_DEF   = 32'sd2;
    localparam int NUM_SYM_DEF = 32'sd3;

    function automatic int clog2_f(input int value);
        int r;
        int v;
        r = 32'sd0;
        v = value - 32'sd1;
        while (v > 32'sd0) begin
            r = r + 32'sd1;
            v = v >>> 32'sd1;
        end
        return (r < 32'sd1) ? 32'sd1 : r;
    endfunction

endpackage

// File: rtl/distinct_window_detector_sym_hist_sreg.sv
// History shift register of the last DEPTH accepted symbols; entry 1 (newest)
// sits in the least significant SYM_W bits of hist_flat.
module sym_hist_sreg #(
    parameter int DEPTH = 2,
    parameter int SYM_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   shift_en,
    input  logic [SYM_W-1:0]       sym_in,
    output logic [DEPTH*SYM_W-1:0] hist_flat
);

    logic [DEPTH*SYM_W-1:0] hist_q;
    logic [DEPTH*SYM_W-1:0] hist_d;
    logic [DEPTH*SYM_W-1:0] shifted_s;

    if (DEPTH == 1) begin : g_single
        assign shifted_s = sym_in;
    end else begin : g_multi
        assign shifted_s = {hist_q[(DEPTH-1)*SYM_W-1:0], sym_in};
    end

    // Next-state: clear wins over shift, otherwise hold
    always_comb begin
        hist_d = hist_q;
        if (clr) begin
            hist_d = '0;
        end else if (shift_en) begin
            hist_d = shifted_s;
        end else begin
            hist_d = hist_q;
        end
    end

    // History storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_q <= '0;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hist_flat = hist_q;

endmodule

// File: rtl/distinct_window_detector.sv
// Detects WIN pairwise-distinct symbols in a row. Optional saturating hit
// counter built only when DISTINCT_DET_HIT_CNT_EN is defined.
module distinct_window_detector
    import distinct_window_detector_pkg::*;
#(
    parameter  int SYM_W   = SYM_W_DEF,
    parameter  int NUM_SYM = NUM_SYM_DEF,
    parameter  int WIN     = 3,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = clog2_f(WIN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [SYM_W-1:0] in_sym,
    input  logic             overlap_en,
    input  logic             clr,
    output logic             det,
    output logic             err,
    output logic [LEN_W-1:0] len,
    output logic [CNT_W-1:0] hit_cnt
);

    if ((WIN < 2) || (WIN > NUM_SYM)) begin : g_bad_win
        $error("distinct_window_detector: WIN must satisfy 2 <= WIN <= NUM_SYM");
    end

    localparam int               HD        = WIN - 1;
    localparam logic [LEN_W-1:0] WIN_L     = LEN_W'(WIN);
    localparam logic [LEN_W-1:0] HD_L      = LEN_W'(WIN - 1);
    localparam logic [SYM_W:0]   NUM_SYM_L = (SYM_W + 1)'(NUM_SYM);

    logic [LEN_W-1:0]    len_q, len_d;
    logic                det_q, det_d;
    logic                err_q, err_d;
    logic                shift_en_s;
    logic                sym_legal_s;
    logic [LEN_W-1:0]    lp_s;
    logic [LEN_W-1:0]    d_s;
    logic [HD*SYM_W-1:0] hist_flat_s;
    logic [SYM_W-1:0]    hist_s [1:HD];

    sym_hist_sreg #(
        .DEPTH (HD),
        .SYM_W (SYM_W)
    ) u_hist (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .shift_en  (shift_en_s),
        .sym_in    (in_sym),
        .hist_flat (hist_flat_s)
    );

    for (genvar g = 1; g <= HD; g++) begin : g_unpack
        assign hist_s[g] = hist_flat_s[(g-1)*SYM_W +: SYM_W];
    end

    assign sym_legal_s = ({1'b0, in_sym} < NUM_SYM_L);

    // Nearest earlier copy of in_sym within the still-distinct suffix sets the new length
    always_comb begin
        if (!overlap_en && (len_q == WIN_L)) begin
            lp_s = '0;
        end else if (len_q > HD_L) begin
            lp_s = HD_L;
        end else begin
            lp_s = len_q;
        end
        d_s = lp_s + LEN_W'(1);
        for (int i = HD; i >= 32'sd1; i--) begin
            d_s = ((LEN_W'(i) <= lp_s) && (hist_s[i] == in_sym)) ? LEN_W'(i) : d_s;
        end
    end

    // Length / error next-state with clr priority over the accepted beat
    always_comb begin
        len_d      = len_q;
        err_d      = 1'b0;
        shift_en_s = 1'b0;
        if (clr) begin
            len_d = '0;
        end else if (in_valid) begin
            if (sym_legal_s) begin
                len_d      = d_s;
                shift_en_s = 1'b1;
            end else begin
                len_d = '0;
                err_d = 1'b1;
            end
        end else begin
            len_d = len_q;
        end
        det_d = (len_d == WIN_L);
    end

    // Registered state and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q <= '0;
            det_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            len_q <= len_d;
            det_q <= det_d;
            err_q <= err_d;
        end
    end

    assign len = len_q;
    assign det = det_q;
    assign err = err_q;

`ifdef DISTINCT_DET_HIT_CNT_EN
    logic [CNT_W-1:0] hit_q, hit_d;

    // Saturating count of beats that complete a window
    always_comb begin
        hit_d = hit_q;
        if (clr) begin
            hit_d = '0;
        end else if (in_valid && sym_legal_s && (d_s == WIN_L) && (hit_q != {CNT_W{1'b1}})) begin
            hit_d = hit_q + CNT_W'(1);
        end else begin
            hit_d = hit_q;
        end
    end

    // Hit counter storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit_d;
        end
    end

    assign hit_cnt = hit_q;
`else
    assign hit_cnt = '0;
`endif

endmodule

// File: tb/tb_distinct_window_detector.sv
// Scoreboard bench: two DUTs (WIN=3/NUM_SYM=3 and WIN=4/NUM_SYM=4/CNT_W=2)
// share one stimulus stream; each has its own reference model.
module tb_distinct_window_detector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [1:0] in_sym;
    logic       overlap_en;
    logic       clr;

    logic       det0, err0;
    logic [1:0] len0;
    logic [7:0] hit0;
    logic       det1, err1;
    logic [2:0] len1;
    logic [1:0] hit1;

    always #5 clk = ~clk;

    distinct_window_detector u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
        .overlap_en(overlap_en), .clr(clr),
        .det(det0), .err(err0), .len(len0), .hit_cnt(hit0)
    );

    distinct_window_detector #(
        .SYM_W(2), .NUM_SYM(4), .WIN(4), .CNT_W(2)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sym(in_sym),
        .overlap_en(overlap_en), .clr(clr),
        .det(det1), .err(err1), .len(len1), .hit_cnt(hit1)
    );

    typedef struct {
        int len;
        int det;
        int err;
        int hit;
    } exp_t;

    exp_t eq0[$];
    exp_t eq1[$];
    int   seq0[$];
    int   seq1[$];
    int   m_len[2];
    int   m_hit[2];
    int   tests = 0;
    int   fails = 0;
    exp_t mon_e;

    // Reference: len is the longest all-distinct suffix of the symbols since
    // the last break (reset, clr, illegal code, consumed window), capped at WIN.
    task automatic model_step(input int id, input bit v, input int s, input bit ov,
                              input bit c, output exp_t e);
        int  win, nsym, cmax, k, sym;
        bit  seen[16];
        int  seq[$];
        win  = (id == 0) ? 3 : 4;
        nsym = (id == 0) ? 3 : 4;
        cmax = (id == 0) ? 255 : 3;
        seq  = (id == 0) ? seq0 : seq1;
        e.err = 0;
        if (c) begin
            seq.delete();
            m_len[id] = 0;
            m_hit[id] = 0;
        end else if (v) begin
            if (s >= nsym) begin
                seq.delete();
                m_len[id] = 0;
                e.err = 1;
            end else begin
                if (!ov && m_len[id] == win) seq.delete();
                seq.push_back(s);
                if (seq.size() > win) void'(seq.pop_front());
                for (int j = 0; j < 16; j++) seen[j] = 1'b0;
                k = 0;
                for (int j = seq.size() - 1; j >= 0; j--) begin
                    sym = seq[j];
                    if (seen[sym]) break;
                    seen[sym] = 1'b1;
                    k++;
                end
                m_len[id] = k;
                if (k == win && m_hit[id] < cmax) m_hit[id]++;
            end
        end
        if (id == 0) seq0 = seq; else seq1 = seq;
        e.len = m_len[id];
        e.det = (m_len[id] == win) ? 1 : 0;
`ifdef DISTINCT_DET_HIT_CNT_EN
        e.hit = m_hit[id];
`else
        e.hit = 0;
`endif
    endtask

    task automatic step(input bit v, input int s, input bit ov, input bit c);
        exp_t e0, e1;
        @(negedge clk);
        in_valid   = v;
        in_sym     = s[1:0];
        overlap_en = ov;
        clr        = c;
        model_step(0, v, s, ov, c, e0);
        model_step(1, v, s, ov, c, e1);
        eq0.push_back(e0);
        eq1.push_back(e1);
    endtask

    task automatic run_seq(input int syms[], input bit ov);
        foreach (syms[i]) step(1'b1, syms[i], ov, 1'b0);
    endtask

    task automatic check_zero(input string name);
        tests++;
        if (det0 !== 1'b0 || err0 !== 1'b0 || len0 !== 2'd0 || hit0 !== 8'd0 ||
            det1 !== 1'b0 || err1 !== 1'b0 || len1 !== 3'd0 || hit1 !== 2'd0) begin
            fails++;
            $display("FAIL %s got det0=%b err0=%b len0=%0d hit0=%0d det1=%b err1=%b len1=%0d hit1=%0d required all 0",
                     name, det0, err0, len0, hit0, det1, err1, len1, hit1);
        end
    endtask

    task automatic model_reset();
        seq0.delete();
        seq1.delete();
        m_len[0] = 0; m_len[1] = 0;
        m_hit[0] = 0; m_hit[1] = 0;
    endtask

    // Monitor: one expected entry per cycle, compared just after the edge
    always @(posedge clk) begin
        #1;
        if (eq0.size() > 0) begin
            mon_e = eq0.pop_front();
            tests++;
            if (int'(len0) != mon_e.len || int'(det0) != mon_e.det ||
                int'(err0) != mon_e.err || int'(hit0) != mon_e.hit) begin
                fails++;
                $display("FAIL win3 @%0t got len=%0d det=%0d err=%0d hit=%0d required len=%0d det=%0d err=%0d hit=%0d",
                         $time, len0, det0, err0, hit0, mon_e.len, mon_e.det, mon_e.err, mon_e.hit);
            end
        end
        if (eq1.size() > 0) begin
            mon_e = eq1.pop_front();
            tests++;
            if (int'(len1) != mon_e.len || int'(det1) != mon_e.det ||
                int'(err1) != mon_e.err || int'(hit1) != mon_e.hit) begin
                fails++;
                $display("FAIL win4 @%0t got len=%0d det=%0d err=%0d hit=%0d required len=%0d det=%0d err=%0d hit=%0d",
                         $time, len1, det1, err1, hit1, mon_e.len, mon_e.det, mon_e.err, mon_e.hit);
            end
        end
    end

    initial begin
        int s, r;
        bit v, ov, c;
        rst_n = 1'b0; in_valid = 1'b0; in_sym = 2'd0; overlap_en = 1'b1; clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        // Basic detect then idle: det holds
        run_seq('{0, 1, 2}, 1'b1);
        repeat (2) step(1'b0, 0, 1'b1, 1'b0);

        // Overlap vs non-overlap on 0,1,2,0,1
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{0, 1, 2, 0, 1}, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{0, 1, 2, 0, 1}, 1'b0);

        // Repeats
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{0, 1, 1, 2, 0, 2, 2}, 1'b1);

        // Gap and illegal code
        step(1'b0, 0, 1'b1, 1'b1);
        step(1'b1, 0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1, 1'b1, 1'b0);
        run_seq('{1, 3, 2}, 1'b1);

        // Async reset while det is high
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{0, 1, 2}, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero("async_reset");
        model_reset();
        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_seq('{1, 2, 0}, 1'b1);

        // Wider window patterns and counter saturation on the CNT_W=2 instance
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{3, 0, 2, 1}, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{3, 0, 3, 1}, 1'b1);
        step(1'b0, 0, 1'b1, 1'b1);
        run_seq('{0, 1, 2, 3, 0, 1, 2, 3, 0}, 1'b1);

        // clr together with a valid beat discards the symbol
        run_seq('{1, 2}, 1'b1);
        step(1'b1, 0, 1'b1, 1'b1);
        step(1'b1, 1, 1'b1, 1'b0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            v  = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            s  = (r == 0) ? 3 : (r % 3);
            if (r == 9) s = $urandom_range(0, 3);
            ov = ($urandom_range(0, 3) != 0);
            c  = ($urandom_range(0, 49) == 0);
            step(v, s, ov, c);
        end

        @(negedge clk);
        in_valid = 1'b0; clr = 1'b0;
        @(posedge clk);
        #3;
        tests++;
        if (eq0.size() != 0 || eq1.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d/%0d pending required 0/0", eq0.size(), eq1.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
